// File: rtl/spi_pkg.sv
// Shared types and constants for the byte-wide mode-0 SPI master.
// Build option: SPI_MISO_SYNC_EN (see spi_master_engine).
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH
  } spi_state_t;

  localparam int SPI_CSR_BUSY     = 0;
  localparam int SPI_CSR_LOOPBACK = 1;
  localparam int SPI_CSR_CS       = 2;

  localparam logic [31:0] SPI_COMMAND_ADDR = 32'h800;
  localparam logic [31:0] SPI_CSR_ADDR     = 32'h801;

endpackage

// File: rtl/spi_master_engine_clk_div.sv
// SCLK half-period divider: down-counter with load/enable and a
// one-cycle phase_end strobe when an enabled count reaches zero.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic phase_end_o
);

  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

  logic [7:0] div_cnt_q;
  logic [7:0] div_cnt_d;

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (load_i) begin
      div_cnt_d = RELOAD;
    end else if (en_i) begin
      div_cnt_d = (div_cnt_q == 8'd0) ? RELOAD
                                      : div_cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt_q <= 8'd0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  assign phase_end_o = en_i && !load_i && (div_cnt_q == 8'd0);

endmodule

// File: rtl/spi_master_engine.sv
// Byte-wide SPI master, mode 0, MSB first, driving CSR BUSY bit.
// Build option: define SPI_MISO_SYNC_EN to add a 2-flop MISO synchronizer.
module spi_master_engine
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire  [7:0] spi_csr,
  input  logic       spi_trigger,
  input  logic [7:0] spi_command,
  output logic [7:0] spi_response,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_cs_n
);

  if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_div_range
    $error("spi_master_engine: CLK_DIV must be in 2..255");
  end

  spi_state_t state_q;
  logic [7:0] tx_q;
  logic [7:0] rx_q;
  logic [7:0] resp_q;
  logic [2:0] bit_cnt_q;
  logic       sclk_q;
  logic       mosi_q;
  logic       busy_q;
  logic       cs_n_q;
  logic       miso_s;
  logic       sample_bit;
  logic       div_load;
  logic       div_en;
  logic       phase_end;

`ifdef SPI_MISO_SYNC_EN
  if (CLK_DIV < 3) begin : g_sync_div
    $error("spi_master_engine: CLK_DIV must be >= 3 with MISO sync");
  end

  logic miso_m_q;
  logic miso_s_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      miso_m_q <= 1'b0;
      miso_s_q <= 1'b0;
    end else begin
      miso_m_q <= spi_miso;
      miso_s_q <= miso_m_q;
    end
  end

  assign miso_s = miso_s_q;
`else
  assign miso_s = spi_miso;
`endif

  assign div_load = (state_q == IDLE) && spi_trigger;
  assign div_en   = (state_q != IDLE);

  spi_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (div_load),
    .en_i       (div_en),
    .phase_end_o(phase_end)
  );

  // Loopback feeds the bit currently on MOSI straight back into RX.
  assign sample_bit = spi_csr[SPI_CSR_LOOPBACK] ? mosi_q : miso_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tx_q      <= 8'h00;
      rx_q      <= 8'h00;
      resp_q    <= 8'h00;
      bit_cnt_q <= 3'd0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      cs_n_q    <= 1'b1;
    end else begin
      cs_n_q <= spi_csr[SPI_CSR_CS];
      unique case (state_q)
        IDLE: begin
          if (spi_trigger) begin
            tx_q      <= spi_command;
            mosi_q    <= spi_command[7];
            bit_cnt_q <= 3'd0;
            busy_q    <= 1'b1;
            state_q   <= LOW;
          end
        end
        LOW: begin
          if (phase_end) begin
            sclk_q  <= 1'b1;
            rx_q    <= {rx_q[6:0], sample_bit};
            state_q <= HIGH;
          end
        end
        HIGH: begin
          if (phase_end) begin
            sclk_q <= 1'b0;
            if (bit_cnt_q == 3'd7) begin
              resp_q  <= rx_q;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              tx_q      <= {tx_q[6:0], 1'b0};
              mosi_q    <= tx_q[6];
              bit_cnt_q <= bit_cnt_q + 3'd1;
              state_q   <= LOW;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign spi_csr[SPI_CSR_BUSY] = busy_q;

  logic unused_csr;
  assign unused_csr = ^spi_csr[7:3];

  assign spi_response = resp_q;
  assign spi_sclk     = sclk_q;
  assign spi_mosi     = mosi_q;
  assign spi_cs_n     = cs_n_q;

endmodule

// File: tb/tb_spi_master_engine.sv
// Scoreboard bench for spi_master_engine: responses queued at trigger,
// popped by a monitor on every BUSY falling edge.
module tb_spi_master_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trig = 1'b0;
  logic [7:0] cmd = 8'h00;
  logic       cs_lvl = 1'b1;
  logic       lb = 1'b0;
  wire  [7:0] spi_csr;
  logic [7:0] resp;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       cs_n;

  int n_tests = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  int rise_cnt = 0;
  int fall_cnt = 0;
  int fall_base = 0;
  int sl_idx;
  logic [7:0] slv_pat = 8'h00;
  logic [7:0] slv_rx = 8'h00;

  assign spi_csr[7:1] = {5'b00000, cs_lvl, lb};

  always #5 clk = ~clk;

  spi_master_engine #(
    .CLK_DIV(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .spi_csr     (spi_csr),
    .spi_trigger (trig),
    .spi_command (cmd),
    .spi_response(resp),
    .spi_sclk    (sclk),
    .spi_mosi    (mosi),
    .spi_miso    (miso),
    .spi_cs_n    (cs_n)
  );

  // Slave model: shifts out slv_pat MSB first, advancing on SCLK falls.
  assign sl_idx = fall_cnt - fall_base;
  assign miso = (sl_idx >= 0 && sl_idx < 8) ? slv_pat[3'(7 - sl_idx)]
                                            : 1'b0;

  always @(negedge sclk) fall_cnt <= fall_cnt + 1;

  always @(posedge sclk) begin
    rise_cnt <= rise_cnt + 1;
    slv_rx   <= {slv_rx[6:0], mosi};
  end

  task automatic check(string nm, logic [71:0] act, logic [71:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every BUSY 1->0 transition must present the queued response.
  initial begin
    logic pb;
    logic [7:0] e;
    pb = 1'b0;
    forever begin
      @(negedge clk);
      if (pb === 1'b1 && spi_csr[0] === 1'b0) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL resp_unexpected: got %0h expected none", resp);
        end else begin
          e = exp_q.pop_front();
          check("response", 72'(resp), 72'(e));
        end
      end
      pb = spi_csr[0];
    end
  end

  task automatic start(input logic [7:0] c);
    @(negedge clk);
    trig = 1'b1;
    cmd  = c;
    @(negedge clk);
    trig = 1'b0;
    cmd  = 8'h00;
  endtask

  task automatic wait_idle(input int bound);
    int k;
    k = 0;
    while (spi_csr[0] !== 1'b0 && k < bound) begin
      @(negedge clk);
      k++;
    end
    if (k >= bound) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_idle: busy %0b after %0d cycles, required 0",
               spi_csr[0], k);
    end
  endtask

  initial begin
    logic [64:0] sc_pat;
    logic [64:0] bz_pat;
    logic [64:0] sc_exp;
    logic [64:0] bz_exp;
    int rb;

    repeat (2) @(negedge clk);
    check("rst_cs_n", 72'(cs_n), 72'(1));
    check("rst_sclk", 72'(sclk), 72'(0));
    check("rst_mosi", 72'(mosi), 72'(0));
    check("rst_busy", 72'(spi_csr[0]), 72'(0));
    check("rst_resp", 72'(resp), 72'(8'h00));
    rst = 1'b0;

    // Loopback A5 with full waveform capture
    lb = 1'b1;
    cs_lvl = 1'b0;
    @(negedge clk);
    exp_q.push_back(8'hA5);
    rb = rise_cnt;
    start(8'hA5);
    for (int i = 0; i <= 64; i++) begin
      sc_pat[i] = sclk;
      bz_pat[i] = spi_csr[0];
      sc_exp[i] = (i < 64) ? 1'((i / 4) % 2) : 1'b0;
      bz_exp[i] = (i < 64);
      if (i < 64) @(negedge clk);
    end
    check("sclk_wave", 72'(sc_pat), 72'(sc_exp));
    check("busy_wave", 72'(bz_pat), 72'(bz_exp));
    check("lb_rises", 72'(rise_cnt - rb), 72'(8));
    check("lb_mosi", 72'(slv_rx), 72'(8'hA5));

    // External slave: send C3, slave returns 3C
    lb = 1'b0;
    slv_pat = 8'h3C;
    fall_base = fall_cnt;
    exp_q.push_back(8'h3C);
    rb = rise_cnt;
    start(8'hC3);
    wait_idle(200);
    check("slv_capture", 72'(slv_rx), 72'(8'hC3));
    check("slv_rises", 72'(rise_cnt - rb), 72'(8));

    // Trigger while busy is ignored
    lb = 1'b1;
    exp_q.push_back(8'h12);
    rb = rise_cnt;
    start(8'h12);
    repeat (8) @(negedge clk);
    start(8'hFF);
    wait_idle(200);
    check("busy_rises", 72'(rise_cnt - rb), 72'(8));
    check("busy_mosi", 72'(slv_rx), 72'(8'h12));
    repeat (5) @(negedge clk);
    check("no_requeue", 72'(spi_csr[0]), 72'(0));

    // Reset mid-transfer aborts without response update
    exp_q.push_back(8'h00);
    start(8'h77);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_sclk", 72'(sclk), 72'(0));
    check("abort_busy", 72'(spi_csr[0]), 72'(0));
    check("abort_resp", 72'(resp), 72'(8'h00));
    rst = 1'b0;
    exp_q.push_back(8'h5A);
    rb = rise_cnt;
    start(8'h5A);
    wait_idle(200);
    check("post_rst_rises", 72'(rise_cnt - rb), 72'(8));
    check("post_rst_mosi", 72'(slv_rx), 72'(8'h5A));

    // CS follows csr[2] with one cycle latency, even mid-transfer
    exp_q.push_back(8'h81);
    start(8'h81);
    repeat (3) @(negedge clk);
    cs_lvl = 1'b1;
    #1;
    check("cs_hold", 72'(cs_n), 72'(0));
    @(negedge clk);
    check("cs_rise", 72'(cs_n), 72'(1));
    cs_lvl = 1'b0;
    #1;
    check("cs_hold1", 72'(cs_n), 72'(1));
    @(negedge clk);
    check("cs_fall", 72'(cs_n), 72'(0));
    wait_idle(200);
    cs_lvl = 1'b1;
    @(negedge clk);
    check("cs_idle", 72'(cs_n), 72'(1));

    repeat (3) @(negedge clk);
    check("queue_empty", 72'(exp_q.size()), 72'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master_engine.md
Name: spi_master_engine

Overview:
- Byte-wide SPI master (mode 0, MSB first) sitting directly downstream of the load/store unit's SPI CSR block.
- Consumes spi_trigger / spi_command, produced when software stores to 0x800.
- Returns spi_response, read back at 0x800.
- Drives bit 0 (BUSY) of the shared spi_csr bus, read back at 0x801, and the external SPI pins.

Parameters:
- CLK_DIV, 4: system clocks per SCLK half-period; legal range 2..255.

Ports:
- clk  input  1  system clock; all state on posedge.
- rst  input  1  synchronous, active-high reset.
- spi_csr  inout  8  shared CSR bus.
  - This block drives bit 0 (BUSY) only; bits 7:1 are left 'z.
  - It reads bit 1 (LOOPBACK) and bit 2 (CS level).
- spi_trigger  input  1  one-cycle start strobe.
- spi_command  input  8  byte to transmit; sampled when spi_trigger is high.
- spi_response  output  8  last received byte.
- spi_sclk  output  1  SPI clock; idle low.
- spi_mosi  output  1  master out.
- spi_miso  input  1  master in.
- spi_cs_n  output  1  chip select; registered copy of spi_csr[2].

Behaviour:
- Reset (rst high at posedge) forces all outputs and state to:
  - state IDLE, BUSY 0, spi_sclk 0, spi_mosi 0, spi_cs_n 1, spi_response 8'h00.
  - Divider and bit counters 0.
  - Reset in any state aborts the transfer with no response update.
- spi_cs_n <= spi_csr[2] every cycle. It is not gated by transfer state; software owns CS framing.
- States: IDLE, LOW, HIGH.
- IDLE:
  - spi_trigger=1 loads tx_shift <= spi_command and sets spi_mosi <= spi_command[7].
  - Same edge: bit_cnt <= 0, div_cnt <= CLK_DIV-1, BUSY <= 1, state -> LOW.
  - spi_trigger in any other state is ignored; there is no queueing.
- LOW:
  - spi_sclk=0; div_cnt decrements each cycle.
  - At div_cnt==0: spi_sclk <= 1, sample rx bit, reload div_cnt, state -> HIGH.
  - Sampled bit = (spi_csr[1] ? spi_mosi : miso_s). miso_s is spi_miso, or its synchronized version when the optional feature is on.
  - Sampling is rx_shift <= {rx_shift[6:0], bit}.
- HIGH:
  - spi_sclk=1; div_cnt decrements each cycle.
  - At div_cnt==0, spi_sclk <= 0 and one of:
    - bit_cnt==7: spi_response <= rx_shift (including the bit sampled this transfer), BUSY <= 0, state -> IDLE.
    - Otherwise: tx_shift shifts left, spi_mosi <= next bit, bit_cnt++, reload div_cnt, state -> LOW.
- Latency:
  - Trigger accepted at edge T; BUSY reads 1 from T+1.
  - spi_response is updated, and BUSY reads 0, from T+16*CLK_DIV+1.
  - Exactly 8 rising SCLK edges per transfer.
- spi_response holds its value until the next completed transfer.
- A trigger in the same cycle as the final falling edge is dropped, because state is not IDLE.
- A LOOPBACK change mid-transfer takes effect at the next sample edge.

Optional Feature:
- Macro: SPI_MISO_SYNC_EN.
- Defined:
  - spi_miso passes through a 2-flop synchronizer (reset 0) before sampling.
  - Sample edge timing is unchanged.
  - CLK_DIV must be ≥3, enforced by elaboration $error.
- Undefined:
  - spi_miso is sampled directly at the SCLK rising edge; CLK_DIV ≥2.

Decomposition:
- Package spi_pkg holds:
  - spi_state_t enum {IDLE, LOW, HIGH}.
  - CSR bit indices SPI_CSR_BUSY=0, SPI_CSR_LOOPBACK=1, SPI_CSR_CS=2.
  - Address constants SPI_COMMAND_ADDR=32'h800, SPI_CSR_ADDR=32'h801.
- One sub-module: spi_clk_div.
  - Contains the div_cnt counter with load/enable.
  - Emits a one-cycle phase_end strobe.
  - The FSM consumes phase_end.

Test Plan:
- Reset check: assert rst for 2 cycles → spi_cs_n=1, spi_sclk=0, spi_mosi=0, spi_csr[0]=0, spi_response=8'h00.
- Loopback, CLK_DIV=4: spi_csr[2:1]=2'b01, trigger with 8'hA5 → BUSY=1 from T+1, 8 SCLK pulses 4 cycles high/4 low; spi_mosi shows 1,0,1,0,0,1,0,1 at rising edges; spi_response=8'hA5 and BUSY=0 at T+65.
- External slave model: send 8'hC3 while the slave returns 8'h3C on spi_miso (changing on SCLK falling edges) → slave captures 8'hC3; spi_response=8'h3C.
- Trigger while busy: second trigger with 8'hFF at T+10 during an 8'h12 loopback transfer → ignored; response 8'h12; still exactly 8 SCLK edges.
- Reset mid-transfer: rst at T+20 → spi_sclk=0 and BUSY=0 next cycle; spi_response=8'h00; a new 8'h5A trigger then completes normally.
- CS follow: toggle spi_csr[2] 1→0→1 → spi_cs_n follows with 1-cycle latency, independent of transfer state.
